// File: rtl/char_buffer_ctrl.sv
// ============================================================================
// char_buffer_ctrl : character-cell line buffer with direct writes, cursor
// pushes, rotate-scroll and a multi-cycle clear sweep. Optional registered
// readback port enabled by CHAR_BUF_READBACK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module char_buffer_ctrl #(
  parameter int              NUM_CHARS = 64,
  parameter int              CHAR_W    = 8,
  parameter int              ADDR_W    = 6,
  parameter logic [CHAR_W-1:0] FILL_CHAR = 8'h00
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_we,
  input  logic [ADDR_W-1:0]             i_wr_addr,
  input  logic [CHAR_W-1:0]             i_din,
  input  logic                          i_push,
  input  logic                          i_clr,
  input  logic                          i_print_fin,
  input  logic                          i_scroll_en,
  output logic [NUM_CHARS*CHAR_W-1:0]   o_dout,
  output logic [ADDR_W-1:0]             o_cursor,
  output logic                          o_busy,
  output logic                          o_drop,
  input  logic [ADDR_W-1:0]             i_rd_addr,
  output logic [CHAR_W-1:0]             o_rd_data
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(NUM_CHARS - 1);
  localparam logic [ADDR_W:0]   c_num  = (ADDR_W+1)'(NUM_CHARS);

  logic [CHAR_W-1:0] r_slot [NUM_CHARS];
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_sweep;
  logic [ADDR_W-1:0] w_sweep_nxt;
  logic [ADDR_W-1:0] r_cursor;
  logic [ADDR_W-1:0] w_cursor_nxt;
  logic              r_drop;
  logic              w_drop_nxt;
  logic              w_do_rot;
  logic              w_do_we;
  logic              w_do_push;
  logic              w_do_clr;
  logic              w_rot_req;
  logic              w_addr_ok;

  assign w_rot_req = i_print_fin & i_scroll_en;
  assign w_addr_ok = ({1'b0, i_wr_addr} < c_num);
  assign w_do_clr  = (r_state == ST_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sweep  <= '0;
      r_cursor <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sweep  <= w_sweep_nxt;
      r_cursor <= w_cursor_nxt;
      r_drop   <= w_drop_nxt;
    end
  end

  // One request served per cycle; anything else asserted that cycle is dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_sweep_nxt  = r_sweep;
    w_cursor_nxt = r_cursor;
    w_drop_nxt   = 1'b0;
    w_do_rot     = 1'b0;
    w_do_we      = 1'b0;
    w_do_push    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_clr) begin
          w_state_nxt = ST_CLEAR;
          w_sweep_nxt = '0;
          w_drop_nxt  = w_rot_req | i_we | i_push;
        end else if (w_rot_req) begin
          w_do_rot   = 1'b1;
          w_drop_nxt = i_we | i_push;
        end else if (i_we) begin
          w_do_we    = w_addr_ok;
          w_drop_nxt = ~w_addr_ok | i_push;
        end else if (i_push) begin
          w_do_push    = 1'b1;
          w_cursor_nxt = (r_cursor == c_last) ? '0 : r_cursor + 1'b1;
        end
      end
      ST_CLEAR: begin
        w_drop_nxt  = i_clr | w_rot_req | i_we | i_push;
        w_sweep_nxt = r_sweep + 1'b1;
        if (r_sweep == c_last) begin
          w_state_nxt  = ST_IDLE;
          w_cursor_nxt = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CHARS; k++) r_slot[k] <= FILL_CHAR;
    end else begin
      for (int k = 0; k < NUM_CHARS; k++) begin
        if (w_do_rot)
          r_slot[k] <= r_slot[(k + 1) % NUM_CHARS];
        else if (w_do_clr && (r_sweep == ADDR_W'(k)))
          r_slot[k] <= FILL_CHAR;
        else if (w_do_we && (i_wr_addr == ADDR_W'(k)))
          r_slot[k] <= i_din;
        else if (w_do_push && (r_cursor == ADDR_W'(k)))
          r_slot[k] <= i_din;
      end
    end
  end

  // Slot 0 occupies the most significant character of the flat bus.
  generate
    for (genvar k = 0; k < NUM_CHARS; k++) begin : g_flat
      assign o_dout[(NUM_CHARS-k)*CHAR_W-1 -: CHAR_W] = r_slot[k];
    end
  endgenerate

  assign o_cursor = r_cursor;
  assign o_busy   = (r_state == ST_CLEAR);
  assign o_drop   = r_drop;

`ifdef CHAR_BUF_READBACK_EN
  logic [CHAR_W-1:0] w_rd_mux;
  logic [CHAR_W-1:0] r_rd_data;

  always_comb begin
    w_rd_mux = FILL_CHAR;
    for (int k = 0; k < NUM_CHARS; k++)
      if (i_rd_addr == ADDR_W'(k)) w_rd_mux = r_slot[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_data <= '0;
    else     r_rd_data <= w_rd_mux;
  end

  assign o_rd_data = r_rd_data;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^i_rd_addr;
  assign o_rd_data   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_char_buffer_ctrl.sv
// Directed self-checking bench for char_buffer_ctrl (default 64-slot build
// plus a 40-slot instance for out-of-range direct writes).
`default_nettype none

module tb_char_buffer_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         we = 0, push = 0, clr = 0, print_fin = 0, scroll_en = 0;
  logic [5:0]   wr_addr = '0, rd_addr = '0;
  logic [7:0]   din = '0;
  logic [511:0] dout;
  logic [5:0]   cursor;
  logic         busy, drop;
  logic [7:0]   rd_data;

  logic         we2 = 0;
  logic [6:0]   wr_addr2 = '0, rd_addr2 = '0;
  logic [7:0]   din2 = '0;
  logic [319:0] dout2;
  logic [6:0]   cursor2;
  logic         busy2, drop2;
  logic [7:0]   rd_data2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  char_buffer_ctrl dut (
    .clk(clk), .rst(rst), .i_we(we), .i_wr_addr(wr_addr), .i_din(din),
    .i_push(push), .i_clr(clr), .i_print_fin(print_fin), .i_scroll_en(scroll_en),
    .o_dout(dout), .o_cursor(cursor), .o_busy(busy), .o_drop(drop),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data)
  );

  char_buffer_ctrl #(.NUM_CHARS(40), .CHAR_W(8), .ADDR_W(7), .FILL_CHAR(8'h00)) dut2 (
    .clk(clk), .rst(rst), .i_we(we2), .i_wr_addr(wr_addr2), .i_din(din2),
    .i_push(1'b0), .i_clr(1'b0), .i_print_fin(1'b0), .i_scroll_en(1'b0),
    .o_dout(dout2), .o_cursor(cursor2), .o_busy(busy2), .o_drop(drop2),
    .i_rd_addr(rd_addr2), .o_rd_data(rd_data2)
  );

  function automatic logic [7:0] slot(int k);
    return dout[(64-k)*8-1 -: 8];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_slot(input logic [5:0] a, input logic [7:0] d);
    we = 1; wr_addr = a; din = d;
    @(negedge clk);
    we = 0;
  endtask

  task automatic test_reset();
    write_slot(6'd7, 8'hAB);
    push = 1; din = 8'h11;
    @(negedge clk);
    push = 0;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (dout !== 512'd0) $display("FAIL reset_dout got=%h exp=0", dout); else pass_cnt++;
    total_cnt++;
    if (cursor !== 6'd0) $display("FAIL reset_cursor got=%0d exp=0", cursor); else pass_cnt++;
    total_cnt++;
    if ({busy, drop} !== 2'b00) $display("FAIL reset_busy_drop got=%b exp=00", {busy, drop}); else pass_cnt++;
    rd_addr = 6'd7;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (rd_data !== 8'h00) $display("FAIL reset_rd_data got=%h exp=00", rd_data); else pass_cnt++;
  endtask

  task automatic test_direct_write();
    do_reset();
    write_slot(6'd0, 8'h48);
    total_cnt++;
    if (dout[511:504] !== 8'h48) $display("FAIL wr_slot0 got=%h exp=48", dout[511:504]); else pass_cnt++;
    write_slot(6'd63, 8'h21);
    total_cnt++;
    if (dout[7:0] !== 8'h21) $display("FAIL wr_slot63 got=%h exp=21", dout[7:0]); else pass_cnt++;
    total_cnt++;
    if ({dout[511:504], drop} !== {8'h48, 1'b0}) $display("FAIL wr_keep got=%h/%b exp=48/0", dout[511:504], drop); else pass_cnt++;
  endtask

  task automatic test_bad_addr();
    logic [319:0] exp2;
    exp2 = '0;
    exp2[7:0] = 8'h11;
    do_reset();
    we2 = 1; wr_addr2 = 7'd39; din2 = 8'h11;
    @(negedge clk);
    wr_addr2 = 7'd64; din2 = 8'hEE;
    @(negedge clk);
    we2 = 0;
    total_cnt++;
    if (drop2 !== 1'b1) $display("FAIL badaddr_drop got=%b exp=1", drop2); else pass_cnt++;
    total_cnt++;
    if (dout2 !== exp2) $display("FAIL badaddr_dout got=%h exp=%h", dout2, exp2); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (drop2 !== 1'b0) $display("FAIL badaddr_drop_pulse got=%b exp=0", drop2); else pass_cnt++;
  endtask

  task automatic test_push_wrap();
    do_reset();
    push = 1;
    for (int i = 0; i < 65; i++) begin
      din = 8'(i);
      @(negedge clk);
      if (i == 62) begin
        total_cnt++;
        if (cursor !== 6'd63) $display("FAIL push_cur63 got=%0d exp=63", cursor); else pass_cnt++;
      end
      if (i == 63) begin
        total_cnt++;
        if (cursor !== 6'd0) $display("FAIL push_wrap0 got=%0d exp=0", cursor); else pass_cnt++;
      end
    end
    push = 0;
    total_cnt++;
    if (cursor !== 6'd1) $display("FAIL push_cur1 got=%0d exp=1", cursor); else pass_cnt++;
    total_cnt++;
    if ({slot(0), slot(1), slot(63)} !== {8'd64, 8'd1, 8'd63})
      $display("FAIL push_slots got=%h,%h,%h exp=40,01,3f", slot(0), slot(1), slot(63));
    else pass_cnt++;
  endtask

  task automatic test_scroll();
    logic [511:0] exp_d;
    exp_d = '0;
    exp_d[511 -: 8] = 8'h42;
    exp_d[503 -: 8] = 8'h43;
    exp_d[7:0]      = 8'h41;
    do_reset();
    write_slot(6'd0, 8'h41);
    write_slot(6'd1, 8'h42);
    write_slot(6'd2, 8'h43);
    print_fin = 1; scroll_en = 1;
    @(negedge clk);
    print_fin = 0;
    total_cnt++;
    if (dout !== exp_d) $display("FAIL scroll_rot got=%h exp=%h", dout, exp_d); else pass_cnt++;
    total_cnt++;
    if ({cursor, drop} !== 7'd0) $display("FAIL scroll_cur_drop got=%0d/%b exp=0/0", cursor, drop); else pass_cnt++;
    scroll_en = 0; print_fin = 1;
    @(negedge clk);
    print_fin = 0;
    total_cnt++;
    if (dout !== exp_d) $display("FAIL scroll_off got=%h exp=%h", dout, exp_d); else pass_cnt++;
    total_cnt++;
    if (drop !== 1'b0) $display("FAIL scroll_off_drop got=%b exp=0", drop); else pass_cnt++;
  endtask

  task automatic test_priority();
    do_reset();
    push = 1;
    din = 8'h01; @(negedge clk);
    din = 8'h02; @(negedge clk);
    din = 8'h03; @(negedge clk);
    print_fin = 1; scroll_en = 1; we = 1; wr_addr = 6'd10; din = 8'h99;
    @(negedge clk);
    print_fin = 0; scroll_en = 0; we = 0; push = 0;
    total_cnt++;
    if ({slot(0), slot(1), slot(2), slot(63)} !== {8'h02, 8'h03, 8'h00, 8'h01})
      $display("FAIL prio_rot got=%h,%h,%h,%h exp=02,03,00,01", slot(0), slot(1), slot(2), slot(63));
    else pass_cnt++;
    total_cnt++;
    if ({slot(10), slot(3)} !== 16'h0000) $display("FAIL prio_nowrite got=%h,%h exp=00,00", slot(10), slot(3)); else pass_cnt++;
    total_cnt++;
    if ({cursor, drop} !== {6'd3, 1'b1}) $display("FAIL prio_cur_drop got=%0d/%b exp=3/1", cursor, drop); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (drop !== 1'b0) $display("FAIL prio_drop_pulse got=%b exp=0", drop); else pass_cnt++;
  endtask

  task automatic test_clear();
    int nbusy;
    do_reset();
    push = 1; din = 8'h55;
    for (int i = 0; i < 5; i++) @(negedge clk);
    push = 0;
    for (int i = 0; i < 64; i++) write_slot(6'(i), 8'h55);
    clr = 1;
    @(negedge clk);
    clr = 0;
    nbusy = 0;
    for (int c = 0; c < 70; c++) begin
      if (busy) nbusy++;
      if (c == 10) begin we = 1; wr_addr = 6'd5; din = 8'hAA; end
      @(negedge clk);
      we = 0;
      if (c == 10) begin
        total_cnt++;
        if (drop !== 1'b1) $display("FAIL clr_we_drop got=%b exp=1", drop); else pass_cnt++;
      end
    end
    total_cnt++;
    if (nbusy != 64) $display("FAIL clr_busy_cycles got=%0d exp=64", nbusy); else pass_cnt++;
    total_cnt++;
    if (dout !== 512'd0) $display("FAIL clr_dout got=%h exp=0", dout); else pass_cnt++;
    total_cnt++;
    if ({cursor, busy, drop} !== 8'd0) $display("FAIL clr_idle got=%0d/%b/%b exp=0/0/0", cursor, busy, drop); else pass_cnt++;
  endtask

  task automatic test_clear_reset();
    do_reset();
    write_slot(6'd63, 8'h77);
    push = 1; din = 8'h66;
    @(negedge clk); @(negedge clk);
    push = 0;
    clr = 1;
    @(negedge clk);
    clr = 0;
    for (int c = 0; c < 20; c++) @(negedge clk);
    total_cnt++;
    if ({busy, slot(63)} !== {1'b1, 8'h77}) $display("FAIL clrrst_mid got=%b/%h exp=1/77", busy, slot(63)); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, drop, cursor} !== 8'd0 || dout !== 512'd0)
      $display("FAIL clrrst_reset got=%b/%b/%0d/%h exp=0/0/0/0", busy, drop, cursor, dout);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL clrrst_stay_idle got=%b exp=0", busy); else pass_cnt++;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_direct_write();
    test_bad_addr();
    test_push_wrap();
    test_scroll();
    test_priority();
    test_clear();
    test_clear_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/char_buffer_ctrl.md
Name: char_buffer_ctrl

Overview:
- Parametrised character-cell buffer that holds the text line shown by the character display pipeline; each slot is one character code.
- Exposes the whole line as a flat bus to the renderer.
- Supports direct-addressed writes, cursor-based streaming writes, rotate-scroll on each completed print, and a multi-cycle clear sweep.

Parameters:
- NUM_CHARS, 64, number of character slots; 2 <= NUM_CHARS <= 2**ADDR_W.
- CHAR_W, 8, bits per character code.
- ADDR_W, 6, width of address and cursor fields.
- FILL_CHAR, 8'h00, code loaded into every slot at reset and during clear; CHAR_W bits wide.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- we  in  1  direct write strobe.
- wr_addr  in  ADDR_W  slot index for we.
- din  in  CHAR_W  character code for we or push.
- push  in  1  cursor write strobe: write din at cursor, then advance cursor.
- clr  in  1  start clear sweep.
- print_fin  in  1  one-cycle pulse, renderer finished one frame.
- scroll_en  in  1  level; when 1, print_fin rotates the line.
- dout  out  NUM_CHARS*CHAR_W  flat line. Slot 0 sits in the MSBs: slot k = dout[(NUM_CHARS-k)*CHAR_W-1 -: CHAR_W].
- cursor  out  ADDR_W  next push slot.
- busy  out  1  clear sweep in progress.
- drop  out  1  one-cycle pulse: a request was discarded.
- rd_addr  in  ADDR_W  readback slot (optional feature).
- rd_data  out  CHAR_W  readback data (optional feature).

Behaviour:
- Reset (async):
  - all slots = FILL_CHAR.
  - cursor = 0, busy = 0, drop = 0, rd_data = 0.
  - FSM = IDLE.
- FSM states: IDLE, CLEAR.
- Latency: every update is visible on dout/cursor the cycle after the sampling edge.
- IDLE, one request served per cycle, priority clr > (print_fin & scroll_en) > we > push:
  - clr: go to CLEAR, sweep index = 0.
  - print_fin & scroll_en: rotate left one slot. Old slot 0 goes to slot NUM_CHARS-1; slot k+1 goes to slot k. cursor unchanged.
  - print_fin with scroll_en = 0: no effect; not a drop.
  - we: slot[wr_addr] = din.
  - push: slot[cursor] = din; cursor = cursor+1. When cursor = NUM_CHARS-1, cursor wraps to 0.
  - Any asserted lower-priority request not served that cycle is discarded and drop = 1 next cycle.
  - we with wr_addr >= NUM_CHARS: no write, drop pulses.
- CLEAR:
  - busy = 1 from the cycle after clr is accepted.
  - Each cycle: slot[sweep index] = FILL_CHAR, then sweep index increments.
  - After writing slot NUM_CHARS-1: cursor = 0, return to IDLE. busy falls on the following cycle.
  - Total: NUM_CHARS cycles with busy high.
  - All requests (we, push, clr, print_fin&scroll_en) during CLEAR are discarded with a drop pulse. A clr during CLEAR does not restart the sweep.
- drop is registered; it is 1 for exactly one cycle per cycle containing at least one discarded request.
- rst asserted mid-sweep: immediate return to reset state; the sweep is abandoned.
- Synthesis: no combinational path from inputs to dout.
- Expected size: about 150–250 lines of RTL.

Optional Feature:
- Macro CHAR_BUF_READBACK_EN.
- Defined:
  - rd_data = slot[rd_addr], registered, 1-cycle latency.
  - Reflects buffer contents as of the sampling edge; same-cycle writes are not forwarded.
  - rd_addr >= NUM_CHARS returns FILL_CHAR.
- Undefined:
  - rd_data is tied to 0 and rd_addr is ignored.
  - No read mux is synthesised.

Test Plan:
- Reset check: rst pulse -> all 64 slots = 8'h00, cursor = 0, busy = 0, drop = 0.
- Direct writes: we, wr_addr = 0, din = 8'h48; then wr_addr = 63, din = 8'h21 -> dout[511:504] = 8'h48 and dout[7:0] = 8'h21 one cycle after each write. Then we, wr_addr = 64 with NUM_CHARS = 40 -> no slot changes, drop pulses once.
- Push wrap: 65 consecutive pushes of din = 0..64 -> slot 0 = 8'd64, slot 1 = 8'd1, slot 63 = 8'd63; cursor wraps 63 -> 0 -> 1.
- Scroll: slots 0..2 = 8'h41, 8'h42, 8'h43, rest 0; print_fin with scroll_en = 1 -> slot 0 = 8'h42, slot 1 = 8'h43, slot 63 = 8'h41. Same pulse with scroll_en = 0 -> unchanged, no drop.
- Priority: print_fin + scroll_en + we + push in the same cycle -> only the rotate occurs, drop = 1 for one cycle, cursor unchanged.
- Clear: write 8'h55 to all slots, assert clr -> busy high exactly 64 cycles, all slots 8'h00, cursor = 0. A we issued mid-sweep is discarded and drop pulses. A second run with rst at sweep index 20 -> immediate full reset values.
